icache_mem_responder: RTL and testbench
=======================================

ICACHE_MEM_RESPONDER -- requirements
Module: icache_mem_responder

Interface
REQ-001 Parameter MEM_WORDS_LOG2, default 12, log2 of backing word count (4096 x 32-bit words).
REQ-002 Parameter LATENCY, default 2, cycles from request accept to resp_valid; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  initiator has a fetch request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address of requested word.
REQ-008 resp_valid  output  1  single-cycle pulse, response data valid.
REQ-009 resp_addr  output  32  req_addr of the request being answered.
REQ-010 resp_rdata  output  32  word read for that request.
REQ-011 kill  input  1  abandon any in-flight request.
REQ-012 load_en / load_addr[MEM_WORDS_LOG2-1:0] / load_data[31:0]  input  synchronous word write port for image loading.

Function
REQ-013 Request accepted in a cycle where req_valid && req_ready && !kill; req_addr latched that edge.
REQ-014 States IDLE, WAIT, RESP; IDLE -> WAIT on accept (LATENCY>1), IDLE -> RESP on accept (LATENCY==1).
REQ-015 WAIT: down-counter loaded with LATENCY-1 at accept, decrements each cycle; WAIT -> RESP when counter reaches 1.
REQ-016 resp_valid SHALL be 1 exactly in RESP, exactly LATENCY cycles after the accept edge; RESP lasts one cycle.
REQ-017 No backpressure: resp_valid is never held; the initiator must take it that cycle.
REQ-018 req_ready SHALL be 1 in IDLE only (see REQ-030 for the exception); at most one outstanding request.
REQ-019 Word index = latched addr[MEM_WORDS_LOG2+1:2]; addr[1:0] ignored (no alignment fault).
REQ-020 Address with any bit above MEM_WORDS_LOG2+1 set SHALL return resp_rdata 32'h0000_0000.
REQ-021 Memory read sampled on the edge entering RESP; a load_en write to the same word on that edge yields the OLD data.
REQ-022 resp_addr and resp_rdata hold their last values outside RESP.
REQ-023 kill: next state IDLE from any state; in-flight request produces no resp_valid; a request presented with kill=1 is not accepted.
REQ-024 kill asserted in RESP does not retract that cycle's resp_valid.
REQ-025 load_en writes load_data at load_addr on the edge regardless of state.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, resp_valid 0, resp_addr 0, resp_rdata 0.
REQ-027 req_ready SHALL be 1 in the first cycle after rst_n deasserts.
REQ-028 Memory contents not cleared by reset; reset mid-request drops the request with no response.

Configuration
REQ-029 Macro ICACHE_RESP_BACK2BACK_EN selects back-to-back acceptance.
REQ-030 Defined: req_ready also 1 in RESP; an accept in RESP goes straight to WAIT/RESP, giving one request per LATENCY cycles.
REQ-031 Undefined: req_ready 0 in RESP; one idle cycle between response and next accept (throughput one per LATENCY+1 cycles).

Verification
REQ-032 Load word 5 = 32'hDEAD_BEEF; req_addr 32'h14, LATENCY=2 -> resp_valid exactly 2 cycles after accept, resp_addr 32'h14, resp_rdata 32'hDEAD_BEEF.
REQ-033 req_addr 32'h17 with word 5 loaded -> resp_rdata 32'hDEAD_BEEF, resp_addr 32'h17.
REQ-034 req_addr 32'h0001_0000 (MEM_WORDS_LOG2=12) -> resp_rdata 32'h0, resp_valid still pulses.
REQ-035 Accept at 32'h0, kill one cycle later -> no resp_valid; req_ready 1 next cycle; fresh request at 32'h4 answered normally.
REQ-036 req_valid held high, addrs 0,4,8 -> resp_valid spacing 2 cycles with ICACHE_RESP_BACK2BACK_EN, 3 without (LATENCY=2).
REQ-037 rst_n low during WAIT -> resp_valid 0 immediately and never pulses for that request; req_ready 1 after release.

Source files
------------

// File: rtl/icache_mem_responder.sv
// Instruction-fetch memory responder: answers one word fetch from a local word array.
// Latency: resp_valid pulses exactly LATENCY cycles after the accept edge (LATENCY 1..15).
// Backpressure: none on responses; req_ready gates one outstanding request.
// Option: define ICACHE_RESP_BACK2BACK_EN to also accept a new request in the response cycle.
module icache_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 12,
  parameter int LATENCY        = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  output logic                      resp_valid,
  output logic [31:0]               resp_addr,
  output logic [31:0]               resp_rdata,
  input  logic                      kill,
  input  logic                      load_en,
  input  logic [MEM_WORDS_LOG2-1:0] load_addr,
  input  logic [31:0]               load_data
);

  localparam int         MEM_WORDS = 1 << MEM_WORDS_LOG2;
  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [31:0]               addr_q, addr_d;
  logic [31:0]               resp_addr_q, resp_rdata_q;
  logic [31:0]               mem_q [MEM_WORDS];

  logic                      accept;
  logic                      rd_en;
  logic                      rd_oob;
  logic [31:0]               rd_addr;
  logic [MEM_WORDS_LOG2-1:0] rd_idx;

`ifdef ICACHE_RESP_BACK2BACK_EN
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_RESP);
`else
  assign req_ready = (state_q == ST_IDLE);
`endif

  // A request presented together with kill is never taken.
  assign accept     = req_valid && req_ready && !kill;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_addr  = resp_addr_q;
  assign resp_rdata = resp_rdata_q;

  // With LATENCY==1 the read happens on the accept edge itself, so use the live address.
  assign rd_addr = accept ? req_addr : addr_q;
  assign rd_idx  = rd_addr[MEM_WORDS_LOG2+1:2];
  assign rd_oob  = (rd_addr >> (MEM_WORDS_LOG2 + 2)) != 32'd0;
  assign rd_en   = (state_d == ST_RESP);

  // Next-state logic: latency countdown, accept, and kill overriding everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_RESP;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      addr_d = req_addr;
      if (LATENCY == 1) begin
        state_d = ST_RESP;
        cnt_d   = 4'd0;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = CNT_LOAD;
      end
    end
    if (kill) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  // Image load port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // Response capture on the edge entering RESP; a same-edge load leaves the old word here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_addr_q  <= 32'd0;
      resp_rdata_q <= 32'd0;
    end else if (rd_en) begin
      resp_addr_q  <= rd_addr;
      resp_rdata_q <= rd_oob ? 32'd0 : mem_q[rd_idx];
    end
  end

endmodule

// File: tb/tb_icache_mem_responder.sv
module tb_icache_mem_responder;

  localparam int MWL = 12;
  localparam int LAT = 2;
`ifdef ICACHE_RESP_BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [31:0]    req_addr;
  logic           resp_valid;
  logic [31:0]    resp_addr;
  logic [31:0]    resp_rdata;
  logic           kill;
  logic           load_en;
  logic [MWL-1:0] load_addr;
  logic [31:0]    load_data;

  icache_mem_responder #(.MEM_WORDS_LOG2(MWL), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_addr  (resp_addr),
    .resp_rdata (resp_rdata),
    .kill       (kill),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: a word map plus "a response is due at cycle N" bookkeeping.
  logic [31:0] m_mem [int];
  bit          m_pend = 1'b0;
  int          m_due = 0;
  logic [31:0] m_paddr = 32'd0;
  bit          m_resp = 1'b0;
  logic [31:0] m_raddr = 32'd0;
  logic [31:0] m_rdata = 32'd0;
  bit          last_acc = 1'b0;

  typedef struct {
    bit          ld;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
    logic [31:0] addr;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[9];

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int idx;
    if ((a >> (MWL + 2)) != 32'd0) return 32'd0;
    idx = int'(a >> 2);
    if (m_mem.exists(idx)) return m_mem[idx];
    return 32'd0;
  endfunction

  function automatic bit m_ready();
    return !m_pend && (!m_resp || B2B);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic check_outputs();
    chkb("resp_valid", resp_valid, m_resp);
    chkb("req_ready", req_ready, m_ready());
    chk("resp_addr", resp_addr, m_raddr);
    chk("resp_rdata", resp_rdata, m_rdata);
  endtask

  // One clock: advance the model with the current inputs, clock the DUT, compare.
  task automatic tick();
    bit acc;
    bit nresp;
    acc   = req_valid && m_ready() && !kill;
    nresp = 1'b0;
    last_acc = acc;
    if (m_pend && !kill && m_due == cyc + 1) begin
      nresp   = 1'b1;
      m_raddr = m_paddr;
      m_rdata = m_read(m_paddr);
    end
    if (nresp || kill) m_pend = 1'b0;
    if (acc) begin
      if (LAT == 1) begin
        nresp   = 1'b1;
        m_raddr = req_addr;
        m_rdata = m_read(req_addr);
      end else begin
        m_pend  = 1'b1;
        m_paddr = req_addr;
        m_due   = cyc + LAT;
      end
    end
    if (load_en) m_mem[int'(load_addr)] = load_data;
    m_resp = nresp;
    @(posedge clk);
    #2;
    cyc++;
    check_outputs();
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    kill      = 1'b0;
    load_en   = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && !m_ready(); i++) tick();
  endtask

  task automatic load_word(input logic [11:0] idx, input logic [31:0] d);
    load_en = 1'b1; load_addr = idx; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Single request; checks acceptance, latency, echoed address and data.
  task automatic do_req(input logic [31:0] a, input logic [31:0] exp_data);
    int lat;
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 1) begin
        chkb("accept", last_acc, 1'b1);
        req_valid = 1'b0;
      end
      if (resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("latency", 32'(lat), 32'(LAT));
    chk("req resp_addr", resp_addr, a);
    chk("req resp_rdata", resp_rdata, exp_data);
  endtask

  task automatic apply_reset_checks();
    chkb("rst resp_valid", resp_valid, 1'b0);
    chk("rst resp_addr", resp_addr, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    m_pend = 1'b0; m_resp = 1'b0; m_raddr = 32'd0; m_rdata = 32'd0;
    @(posedge clk); @(posedge clk);
    cyc += 2;
    #2;
    rst_n = 1'b1;
    #1;
    chkb("ready after reset", req_ready, 1'b1);
  endtask

  initial begin
    int t_resp[3];
    int nr;
    int k;
    int seen;
    rst_n = 1'b0;
    req_addr = 32'd0; load_addr = '0; load_data = 32'd0;
    idle_inputs();
    #1;
    apply_reset_checks();

    for (int i = 0; i < 16; i++) load_word(12'(i), 32'hC0DE_0000 + 32'(i));

    vt[0] = '{1'b1, 12'd5,    32'hDEAD_BEEF, 32'h0000_0014, 32'hDEAD_BEEF};
    vt[1] = '{1'b0, 12'd0,    32'h0,         32'h0000_0017, 32'hDEAD_BEEF};
    vt[2] = '{1'b0, 12'd0,    32'h0,         32'h0001_0000, 32'h0000_0000};
    vt[3] = '{1'b1, 12'd4095, 32'h1234_5678, 32'h0000_3FFC, 32'h1234_5678};
    vt[4] = '{1'b0, 12'd0,    32'h0,         32'h0000_3FFF, 32'h1234_5678};
    vt[5] = '{1'b0, 12'd0,    32'h0,         32'h0000_4000, 32'h0000_0000};
    vt[6] = '{1'b0, 12'd0,    32'h0,         32'h8000_0014, 32'h0000_0000};
    vt[7] = '{1'b0, 12'd0,    32'h0,         32'h0000_0008, 32'hC0DE_0002};
    vt[8] = '{1'b0, 12'd0,    32'h0,         32'h0000_003D, 32'hC0DE_000F};
    for (int v = 0; v < 9; v++) begin
      if (vt[v].ld) load_word(vt[v].ld_idx, vt[v].ld_data);
      do_req(vt[v].addr, vt[v].exp);
    end

    // Kill one cycle after accept: no response, ready again, next request normal.
    wait_ready();
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    chkb("kill accept", last_acc, 1'b1);
    req_valid = 1'b0; kill = 1'b1;
    tick();
    kill = 1'b0;
    chkb("ready after kill", req_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    chk("killed resp count", 32'(seen), 32'd0);
    do_req(32'h4, 32'hC0DE_0001);

    // Load to the word being read on the edge entering RESP returns the old word.
    wait_ready();
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    repeat (LAT - 2) tick();
    load_word(12'd3, 32'hFEED_F00D);
    chkb("same-edge resp_valid", resp_valid, 1'b1);
    chk("same-edge old data", resp_rdata, 32'hC0DE_0003);
    do_req(32'hC, 32'hFEED_F00D);

    // Held req_valid over addresses 0,4,8: response spacing.
    wait_ready();
    req_valid = 1'b1; req_addr = 32'h0;
    k = 0; nr = 0;
    for (int i = 0; i < 40 && nr < 3; i++) begin
      tick();
      if (last_acc) begin
        k++;
        if (k == 3) req_valid = 1'b0;
        else req_addr = 32'(k * 4);
      end
      if (resp_valid === 1'b1) begin
        t_resp[nr] = cyc;
        nr++;
      end
    end
    req_valid = 1'b0;
    chk("stream resp count", 32'(nr), 32'd3);
    if (nr == 3) begin
      chk("spacing 0-1", 32'(t_resp[1] - t_resp[0]), B2B ? 32'(LAT) : 32'(LAT + 1));
      chk("spacing 1-2", 32'(t_resp[2] - t_resp[1]), B2B ? 32'(LAT) : 32'(LAT + 1));
    end

    // Reset while waiting: outputs clear at once, request is dropped.
    wait_ready();
    req_valid = 1'b1; req_addr = 32'h20;
    tick();
    req_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    apply_reset_checks();
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (resp_valid === 1'b1) seen++;
    end
    chk("resp after reset", 32'(seen), 32'd0);
    do_req(32'h20, 32'hC0DE_0008);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      req_valid = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r < 7) req_addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      else if (r == 7) req_addr = 32'h3FFC + 32'($urandom_range(0, 3));
      else req_addr = $urandom | 32'h0001_0000;
      kill = ($urandom_range(0, 15) == 0);
      load_en = ($urandom_range(0, 3) == 0);
      load_addr = ($urandom_range(0, 7) == 0) ? 12'd4095 : 12'($urandom_range(0, 15));
      load_data = $urandom;
      tick();
    end
    idle_inputs();
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
